// File: rtl/edge_scan_sequencer.sv
// Raster-scan sequencer feeding 3x3 neighbourhoods to the edge core and writing packed results.
// Optional column reuse between horizontally adjacent windows: define EDGE_SCAN_COLUMN_REUSE_EN.
module edge_scan_sequencer #(
  parameter int          IMG_W    = 28,
  parameter int          IMG_H    = 28,
  parameter logic [31:0] SRC_BASE = 32'h1000_0000,
  parameter logic [31:0] DST_BASE = 32'h1000_1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_req,
  output logic [31:0]       rd_addr,
  input  logic              rd_gnt,
  input  logic              rd_rvalid,
  input  logic [31:0]       rd_rdata,
  output logic              wr_req,
  output logic [31:0]       wr_addr,
  output logic [31:0]       wr_wdata,
  input  logic              wr_gnt,
  output logic              win_valid,
  output logic signed [7:0] p00,
  output logic signed [7:0] p01,
  output logic signed [7:0] p02,
  output logic signed [7:0] p10,
  output logic signed [7:0] p12,
  output logic signed [7:0] p20,
  output logic signed [7:0] p21,
  output logic signed [7:0] p22,
  input  logic              core_rvalid,
  input  logic [15:0]       core_result
);

  localparam int DATA_W = 8;
`ifdef EDGE_SCAN_COLUMN_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif
  localparam logic [7:0] X_LAST = 8'(IMG_W - 2);
  localparam logic [7:0] Y_LAST = 8'(IMG_H - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_PRESENT, S_RES_WAIT, S_WRITE, S_NEXT, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [7:0]               x, y, x_nxt, y_nxt;
  logic [1:0]               fcol, frow, fcol_nxt, frow_nxt;
  logic [15:0]              widx;
  logic signed [DATA_W-1:0] win [3][3];
  logic signed [DATA_W-1:0] pix_in;
  logic                     last_fetch, last_col, last_centre;
  logic                     unused_rdata;

  function automatic logic [31:0] src_addr(input logic [7:0] cx, input logic [7:0] cy);
    return SRC_BASE + ((32'(cy) * 32'(IMG_W) + 32'(cx)) << 2);
  endfunction

  assign pix_in       = $signed(rd_rdata[7:0]);
  assign unused_rdata = &{1'b0, rd_rdata[31:8]};
  assign last_fetch   = (fcol == 2'd2) && (frow == 2'd2);
  assign last_col     = (x == X_LAST);
  assign last_centre  = last_col && (y == Y_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start)       state_nxt = S_RD_REQ;
      S_RD_REQ:   if (rd_gnt)      state_nxt = S_RD_WAIT;
      S_RD_WAIT:  if (rd_rvalid)   state_nxt = last_fetch ? S_PRESENT : S_RD_REQ;
      S_PRESENT:                   state_nxt = S_RES_WAIT;
      S_RES_WAIT: if (core_rvalid) state_nxt = S_WRITE;
      S_WRITE:    if (wr_gnt)      state_nxt = S_NEXT;
      S_NEXT:                      state_nxt = last_centre ? S_DONE : S_RD_REQ;
      S_DONE:                      state_nxt = S_IDLE;
      default:                     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    rd_req    = (state == S_RD_REQ);
    wr_req    = (state == S_WRITE);
    win_valid = (state == S_PRESENT);
  end

  // Fetch order: columns left to right, rows top to bottom within a column.
  always_comb begin
    x_nxt    = x;
    y_nxt    = y;
    fcol_nxt = fcol;
    frow_nxt = frow;
    case (state)
      S_IDLE: if (start) begin
        x_nxt    = 8'd1;
        y_nxt    = 8'd1;
        fcol_nxt = 2'd0;
        frow_nxt = 2'd0;
      end
      S_RD_WAIT: if (rd_rvalid && !last_fetch) begin
        if (frow == 2'd2) begin
          frow_nxt = 2'd0;
          fcol_nxt = fcol + 2'd1;
        end else begin
          frow_nxt = frow + 2'd1;
        end
      end
      S_NEXT: begin
        frow_nxt = 2'd0;
        if (last_col) begin
          x_nxt    = 8'd1;
          y_nxt    = y + 8'd1;
          fcol_nxt = 2'd0;
        end else begin
          x_nxt    = x + 8'd1;
          fcol_nxt = REUSE ? 2'd2 : 2'd0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x    <= '0;
      y    <= '0;
      fcol <= '0;
      frow <= '0;
    end else begin
      x    <= x_nxt;
      y    <= y_nxt;
      fcol <= fcol_nxt;
      frow <= frow_nxt;
    end
  end

  // Address is captured on entry to RD_REQ so it cannot move while the grant is pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= '0;
    end else if (state_nxt == S_RD_REQ && state != S_RD_REQ) begin
      rd_addr <= src_addr(x_nxt + {6'd0, fcol_nxt} - 8'd1, y_nxt + {6'd0, frow_nxt} - 8'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_RD_WAIT && rd_rvalid) begin
      win[fcol][frow] <= pix_in;
    end else if (REUSE && state == S_NEXT && !last_col) begin
      win[0] <= win[1];
      win[1] <= win[2];
    end
  end

  // Window presentation: the final fetch (bottom-right) bypasses the window store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p00 <= '0; p01 <= '0; p02 <= '0; p10 <= '0;
      p12 <= '0; p20 <= '0; p21 <= '0; p22 <= '0;
    end else if (state == S_RD_WAIT && rd_rvalid && last_fetch) begin
      p00 <= win[0][0];
      p01 <= win[1][0];
      p02 <= win[2][0];
      p10 <= win[0][1];
      p12 <= win[2][1];
      p20 <= win[0][2];
      p21 <= win[1][2];
      p22 <= pix_in;
    end
  end

  // Result capture and write-back; results are packed densely in raster order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      widx     <= '0;
      wr_addr  <= '0;
      wr_wdata <= '0;
    end else begin
      if (state == S_IDLE && start)       widx <= '0;
      else if (state == S_WRITE && wr_gnt) widx <= widx + 16'd1;
      if (state == S_RES_WAIT && core_rvalid) begin
        wr_addr  <= DST_BASE + {14'd0, widx, 2'b00};
        wr_wdata <= {16'd0, core_result};
      end
    end
  end

endmodule

// File: tb/tb_edge_scan_sequencer.sv
// Scoreboard bench for edge_scan_sequencer on a 5x4 image: memory/core responders with
// optional stalls, a read/window/write monitor, and directed start/reset scenarios.
module tb_edge_scan_sequencer;

  localparam int          W   = 5;
  localparam int          H   = 4;
  localparam logic [31:0] SRC = 32'h1000_0000;
  localparam logic [31:0] DST = 32'h1000_1000;
`ifdef EDGE_SCAN_COLUMN_REUSE_EN
  localparam bit REUSE  = 1'b1;
  localparam int EXP_RD = (H - 2) * (9 + 3 * (W - 3));
`else
  localparam bit REUSE  = 1'b0;
  localparam int EXP_RD = 9 * (W - 2) * (H - 2);
`endif
  localparam int EXP_WR = (W - 2) * (H - 2);

  logic clk, rst_n, start, busy, done;
  logic rd_req, rd_gnt, rd_rvalid, wr_req, wr_gnt, win_valid, core_rvalid;
  logic [31:0] rd_addr, rd_rdata, wr_addr, wr_wdata;
  logic [15:0] core_result;
  logic signed [7:0] p00, p01, p02, p10, p12, p20, p21, p22;

  edge_scan_sequencer #(.IMG_W(W), .IMG_H(H), .SRC_BASE(SRC), .DST_BASE(DST)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_rvalid(rd_rvalid),
    .rd_rdata(rd_rdata), .wr_req(wr_req), .wr_addr(wr_addr), .wr_wdata(wr_wdata),
    .wr_gnt(wr_gnt), .win_valid(win_valid), .p00(p00), .p01(p01), .p02(p02),
    .p10(p10), .p12(p12), .p20(p20), .p21(p21), .p22(p22),
    .core_rvalid(core_rvalid), .core_result(core_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_rd_q[$];
  logic [63:0] exp_wr_q[$];
  logic [63:0] exp_win_q[$];
  logic [31:0] rd_log[$];
  logic [63:0] wr_log[$];
  int n_rd, n_wr, n_win, n_done;
  int stall_max;
  bit spur_en;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [7:0] pix(input int c, input int r);
    return 8'((r * W + c) * 37 + 5);
  endfunction

  function automatic logic [7:0] pix_at(input logic [31:0] a);
    int idx;
    idx = int'((a - SRC) >> 2);
    return 8'(idx * 37 + 5);
  endfunction

  function automatic int sx(input logic [7:0] v);
    logic signed [7:0] t;
    t = v;
    return int'(t);
  endfunction

  function automatic logic [15:0] core_fn(input logic [7:0] a00, a01, a02, a10,
                                          input logic [7:0] a12, a20, a21, a22);
    int s;
    s = sx(a00) + 2 * sx(a01) + 3 * sx(a02) + 5 * sx(a10)
      + 7 * sx(a12) + 11 * sx(a20) + 13 * sx(a21) + 17 * sx(a22);
    return 16'(s);
  endfunction

  function automatic int pick();
    return (stall_max == 0) ? 0 : int'($urandom_range(32'(stall_max), 0));
  endfunction

  task automatic begin_scan();
    logic [7:0] a00, a01, a02, a10, a12, a20, a21, a22;
    n_rd = 0; n_wr = 0; n_win = 0; n_done = 0;
    rd_log.delete();
    wr_log.delete();
    for (int y = 1; y <= H - 2; y++) begin
      for (int x = 1; x <= W - 2; x++) begin
        for (int col = 0; col < 3; col++) begin
          if (!(REUSE && x > 1 && col < 2)) begin
            for (int row = 0; row < 3; row++)
              exp_rd_q.push_back(SRC + 32'(((y - 1 + row) * W + (x - 1 + col)) * 4));
          end
        end
        a00 = pix(x - 1, y - 1); a01 = pix(x, y - 1); a02 = pix(x + 1, y - 1);
        a10 = pix(x - 1, y);     a12 = pix(x + 1, y);
        a20 = pix(x - 1, y + 1); a21 = pix(x, y + 1); a22 = pix(x + 1, y + 1);
        exp_win_q.push_back({a00, a01, a02, a10, a12, a20, a21, a22});
        exp_wr_q.push_back({DST + 32'(((y - 1) * (W - 2) + (x - 1)) * 4),
                            16'd0, core_fn(a00, a01, a02, a10, a12, a20, a21, a22)});
      end
    end
  endtask

  task automatic pulse_start(input string name);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, "_busy_after_start"}, 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (done) break;
    end
    chk({name, "_done_seen"}, 64'(done), 64'd1);
    chk({name, "_busy_in_done"}, 64'(busy), 64'd1);
  endtask

  task automatic end_scan(input string name);
    chk({name, "_busy_after_done"}, 64'(busy), 64'd0);
    chk({name, "_reads"}, 64'(n_rd), 64'(EXP_RD));
    chk({name, "_writes"}, 64'(n_wr), 64'(EXP_WR));
    chk({name, "_windows"}, 64'(n_win), 64'(EXP_WR));
    chk({name, "_done_pulses"}, 64'(n_done), 64'd1);
    chk({name, "_pending"}, 64'(exp_rd_q.size() + exp_wr_q.size() + exp_win_q.size()), 64'd0);
  endtask

  // Memory, core and monitor responder: decides inputs for the next rising edge.
  bit rd_out, rd_seen, wr_seen, core_pend;
  int rv_dly, rd_st, wr_st, core_cnt;
  logic [31:0] rd_hold, rd_out_addr;
  logic [63:0] wr_hold;
  logic [15:0] core_val;

  initial begin
    rd_gnt = 0; rd_rvalid = 0; rd_rdata = '0; wr_gnt = 0; core_rvalid = 0; core_result = '0;
    rd_out = 0; rd_seen = 0; wr_seen = 0; core_pend = 0;
    forever begin
      @(negedge clk);
      rd_gnt = 0; rd_rvalid = 0; wr_gnt = 0; core_rvalid = 0;
      if (!rst_n) begin
        rd_out = 0; rd_seen = 0; wr_seen = 0; core_pend = 0;
        continue;
      end
      if (done) n_done++;
      if (rd_out) begin
        if (rv_dly == 0) begin
          rd_rvalid = 1;
          rd_rdata  = {24'($urandom), pix_at(rd_out_addr)};
          rd_out    = 0;
        end else rv_dly--;
      end else if (rd_req) begin
        if (!rd_seen) begin
          rd_seen = 1; rd_hold = rd_addr; rd_st = pick();
        end else chk("rd_addr_stable", 64'(rd_addr), 64'(rd_hold));
        if (rd_st == 0) begin
          rd_gnt = 1; rd_out = 1; rd_out_addr = rd_addr; rv_dly = pick(); rd_seen = 0;
          n_rd++;
          rd_log.push_back(rd_addr);
          if (exp_rd_q.size() == 0) chk("rd_unexpected", 64'(rd_addr), 64'd0);
          else chk("rd_addr", 64'(rd_addr), 64'(exp_rd_q.pop_front()));
        end else rd_st--;
      end
      if (wr_req) begin
        if (!wr_seen) begin
          wr_seen = 1; wr_hold = {wr_addr, wr_wdata}; wr_st = pick();
        end else chk("wr_stable", {wr_addr, wr_wdata}, wr_hold);
        if (wr_st == 0) begin
          wr_gnt = 1; wr_seen = 0;
          n_wr++;
          wr_log.push_back({wr_addr, wr_wdata});
          if (exp_wr_q.size() == 0) chk("wr_unexpected", {wr_addr, wr_wdata}, 64'd0);
          else chk("wr_addr_data", {wr_addr, wr_wdata}, exp_wr_q.pop_front());
        end else wr_st--;
      end
      if (win_valid) begin
        n_win++;
        if (exp_win_q.size() == 0) chk("win_unexpected", {p00, p01, p02, p10, p12, p20, p21, p22}, 64'd0);
        else chk("window", {p00, p01, p02, p10, p12, p20, p21, p22}, exp_win_q.pop_front());
        core_pend = 1;
        core_cnt  = pick();
        core_val  = core_fn(p00, p01, p02, p10, p12, p20, p21, p22);
      end else if (core_pend) begin
        if (core_cnt == 0) begin
          core_rvalid = 1; core_result = core_val; core_pend = 0;
        end else core_cnt--;
      end else if (spur_en && $urandom_range(3, 0) == 0) begin
        core_rvalid = 1; core_result = 16'hDEAD;
      end
    end
  end

  task automatic chk_all_zero(input string name);
    chk({name, "_ctrl"}, 64'({busy, done, rd_req, wr_req, win_valid}), 64'd0);
    chk({name, "_rd_addr"}, 64'(rd_addr), 64'd0);
    chk({name, "_wr_addr_data"}, {wr_addr, wr_wdata}, 64'd0);
    chk({name, "_window"}, {p00, p01, p02, p10, p12, p20, p21, p22}, 64'd0);
  endtask

  initial begin
    int nw;
    rst_n = 1'b0; start = 1'b0; stall_max = 0; spur_en = 0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Scan A: no stalls, directed first-window values.
    begin_scan();
    pulse_start("A");
    wait_done("A");
    @(negedge clk);
    end_scan("A");
    chk("A_first_write", wr_log[0], {DST, 32'h0000_FC0E});
    chk("A_last_write_addr", 64'(wr_log[EXP_WR - 1][63:32]), 64'(DST + 32'd20));
    chk("A_first_read", 64'(rd_log[0]), 64'(SRC));
`ifdef EDGE_SCAN_COLUMN_REUSE_EN
    chk("A_win2_rd0", 64'(rd_log[9]),  64'(SRC + 32'd12));
    chk("A_win2_rd1", 64'(rd_log[10]), 64'(SRC + 32'd32));
    chk("A_win2_rd2", 64'(rd_log[11]), 64'(SRC + 32'd52));
`else
    chk("A_win2_rd0", 64'(rd_log[9]),  64'(SRC + 32'd4));
    chk("A_win2_rd8", 64'(rd_log[17]), 64'(SRC + 32'd52));
`endif

    // Scan B: stalls, spurious core strobes, start pulses mid-scan and in the done cycle.
    stall_max = 5; spur_en = 1;
    begin_scan();
    pulse_start("B");
    repeat (20) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (40) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done("B");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    end_scan("B");
    repeat (3) @(negedge clk);
    chk("B_no_restart", 64'({busy, rd_req, wr_req}), 64'd0);

    // Scan C then D: start in the cycle right after done begins a new scan.
    stall_max = 3; spur_en = 0;
    begin_scan();
    pulse_start("C");
    wait_done("C");
    @(negedge clk);
    end_scan("C");
    stall_max = 5; spur_en = 1;
    begin_scan();
    pulse_start("D");
    wait_done("D");
    @(negedge clk);
    end_scan("D");

    // Scan E: reset while waiting for the core result.
    begin_scan();
    pulse_start("E");
    nw = 0;
    for (int k = 0; k < 20000 && nw < 3; k++) begin
      @(negedge clk);
      if (win_valid) nw++;
    end
    chk("E_windows_before_reset", 64'(nw), 64'd3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("E_reset");
    exp_rd_q.delete(); exp_wr_q.delete(); exp_win_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("E_idle_after_reset", 64'({busy, done, rd_req}), 64'd0);
    begin_scan();
    pulse_start("F");
    wait_done("F");
    @(negedge clk);
    end_scan("F");
    chk("F_first_read", 64'(rd_log[0]), 64'(SRC));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
